// File: rtl/decode_prefetch_queue.sv
// Byte-granular prefetch queue between instruction fetch and decode.
// Fetch pushes 1..4 bytes per cycle; decode sees an 8-byte window and retires 1..8 bytes.
module decode_prefetch_queue #(
    parameter int DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_data,
    input  logic [2:0]  i_fetch_bytes,
    output logic        o_fetch_ready,
    output logic [7:0]  o_window [0:7],
    output logic [3:0]  o_window_count,
    input  logic        i_consume_valid,
    input  logic [3:0]  i_consume_bytes,
    output logic        o_empty,
    output logic        o_full,
    output logic        o_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          error_q, error_d;

    logic [3:0]    win_cnt;
    logic [2:0]    fetch_n;
    logic          fetch_acc;
    logic          cons_ok;
    logic          cons_acc;
    logic          cons_ill;

    always_comb begin
        win_cnt       = (count_q >= CW'(8)) ? 4'd8 : 4'(count_q);
        // Ready depends only on registered count so consume cannot combinationally gate fetch.
        o_fetch_ready = (count_q <= CW'(DEPTH - 4));
        fetch_n       = (i_fetch_bytes > 3'd4) ? 3'd4 : i_fetch_bytes;
        fetch_acc     = i_fetch_valid & o_fetch_ready & ~i_flush & (fetch_n != 3'd0);
        cons_ok       = (i_consume_bytes != 4'd0) && (i_consume_bytes <= win_cnt);
        cons_acc      = i_consume_valid & ~i_flush & cons_ok;
        cons_ill      = i_consume_valid & ~i_flush & ~cons_ok;
    end

    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < 4; k++) begin
            if (fetch_acc && (3'(k) < fetch_n))
                mem_d[wr_ptr_q + AW'(k)] = i_fetch_data[8*k +: 8];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = error_q | cons_ill;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fetch_acc) wr_ptr_d = wr_ptr_q + AW'(fetch_n);
            if (cons_acc)  rd_ptr_d = rd_ptr_q + AW'(i_consume_bytes);
            count_d = count_q
                    + (fetch_acc ? CW'(fetch_n) : CW'(0))
                    - (cons_acc  ? CW'(i_consume_bytes) : CW'(0));
        end
    end

    // Byte storage is not reset; stale bytes are masked by the window count.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            o_window[k] = (4'(k) < win_cnt) ? mem_q[rd_ptr_q + AW'(k)] : 8'h00;
        end
        o_window_count = win_cnt;
        o_empty        = (count_q == '0);
        o_full         = (count_q == CW'(DEPTH));
        o_error        = error_q;
    end

endmodule

// File: tb/tb_decode_prefetch_queue.sv
// Self-checking bench for decode_prefetch_queue: a byte-queue scoreboard tracks
// what the window must show after every driven cycle.
module tb_decode_prefetch_queue;

    localparam int DEPTH = 16;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_fetch_valid = 1'b0;
    logic [31:0] i_fetch_data = '0;
    logic [2:0]  i_fetch_bytes = '0;
    logic        o_fetch_ready;
    logic [7:0]  o_window [0:7];
    logic [3:0]  o_window_count;
    logic        i_consume_valid = 1'b0;
    logic [3:0]  i_consume_bytes = '0;
    logic        o_empty;
    logic        o_full;
    logic        o_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [$];
    logic       m_err = 1'b0;

    decode_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_flush         (i_flush),
        .i_fetch_valid   (i_fetch_valid),
        .i_fetch_data    (i_fetch_data),
        .i_fetch_bytes   (i_fetch_bytes),
        .o_fetch_ready   (o_fetch_ready),
        .o_window        (o_window),
        .o_window_count  (o_window_count),
        .i_consume_valid (i_consume_valid),
        .i_consume_bytes (i_consume_bytes),
        .o_empty         (o_empty),
        .o_full          (o_full),
        .o_error         (o_error)
    );

    always #5 i_clk = ~i_clk;

    // Drive one cycle of stimulus, let the edge happen, then update the scoreboard.
    task automatic step(input bit fv, input logic [31:0] fd, input logic [2:0] fb,
                        input bit cv, input logic [3:0] cb, input bit fl);
        bit f_acc, c_acc, c_ill;
        int wc;
        wc = (sb.size() > 8) ? 8 : sb.size();
        f_acc = fv && !fl && (DEPTH - sb.size() >= 4);
        c_acc = cv && !fl && (cb >= 1) && (int'(cb) <= wc);
        c_ill = cv && !fl && !c_acc;
        i_fetch_valid = fv; i_fetch_data = fd; i_fetch_bytes = fb;
        i_consume_valid = cv; i_consume_bytes = cb; i_flush = fl;
        @(posedge i_clk); #1;
        if (fl) sb.delete();
        else begin
            if (c_acc) for (int k = 0; k < int'(cb); k++) void'(sb.pop_front());
            if (f_acc) for (int k = 0; k < int'(fb); k++) sb.push_back(fd[8*k +: 8]);
        end
        if (c_ill) m_err = 1'b1;
        i_fetch_valid = 0; i_consume_valid = 0; i_flush = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (o_empty !== 1'b1 || o_full !== 1'b0 || o_fetch_ready !== 1'b1 ||
            o_window_count !== 4'd0 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: empty=%b full=%b ready=%b cnt=%0d err=%b, need 1 0 1 0 0",
                     o_empty, o_full, o_fetch_ready, o_window_count, o_error);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_window[k] !== 8'h00) begin
                errors++;
                $display("FAIL reset_window[%0d]: got %h need 00", k, o_window[k]);
            end
        end
        @(posedge i_clk); #3 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_single_fetch();
        logic [7:0] want [0:7];
        want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        step(1, 32'h44332211, 3'd4, 0, 4'd0, 0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_window[k] !== want[k]) begin
                errors++;
                $display("FAIL single_fetch_win[%0d]: got %h need %h", k, o_window[k], want[k]);
            end
        end
        checks++;
        if (o_window_count !== 4'd4 || o_empty !== 1'b0) begin
            errors++;
            $display("FAIL single_fetch_cnt: cnt=%0d empty=%b need 4 0", o_window_count, o_empty);
        end
    endtask

    task automatic test_full();
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_full !== 1'b0 || o_fetch_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_%0d: full=%b ready=%b need 0 1", i, o_full, o_fetch_ready);
            end
            step(1, 32'hA0A1A2A3 + 32'(i), 3'd4, 0, 0, 0);
        end
        checks++;
        if (o_full !== 1'b1 || o_fetch_ready !== 1'b0 || o_empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flags: full=%b ready=%b empty=%b need 1 0 0", o_full, o_fetch_ready, o_empty);
        end
        step(1, 32'hDEADBEEF, 3'd4, 0, 0, 0);
        checks++;
        if (o_full !== 1'b1 || o_error !== 1'b0 || o_window_count !== 4'd8 || sb.size() != 16) begin
            errors++;
            $display("FAIL full_ignore: full=%b err=%b cnt=%0d need 1 0 8", o_full, o_error, o_window_count);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_window[k] !== sb[k]) begin
                errors++;
                $display("FAIL full_win[%0d]: got %h need %h", k, o_window[k], sb[k]);
            end
        end
        // Drain the full queue in two 8-byte consumes.
        step(0, 0, 0, 1, 4'd8, 0);
        step(0, 0, 0, 1, 4'd8, 0);
        checks++;
        if (o_empty !== 1'b1 || o_window_count !== 4'd0) begin
            errors++;
            $display("FAIL drain: empty=%b cnt=%0d need 1 0", o_empty, o_window_count);
        end
    endtask

    task automatic test_simultaneous();
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h03020100, 3'd4, 0, 0, 0);
        step(1, 32'h00000504, 3'd2, 0, 0, 0);
        step(1, 32'h09080706, 3'd4, 1, 4'd3, 0);
        checks++;
        if (o_window_count !== 4'd7 || o_window[0] !== 8'h03) begin
            errors++;
            $display("FAIL simul: cnt=%0d win0=%h need 7 03", o_window_count, o_window[0]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_window[k] !== ((k < sb.size()) ? sb[k] : 8'h00)) begin
                errors++;
                $display("FAIL simul_win[%0d]: got %h need %h", k, o_window[k],
                         (k < sb.size()) ? sb[k] : 8'h00);
            end
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h13121110, 3'd4, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] w;
            w = {8'(4*i+23), 8'(4*i+22), 8'(4*i+21), 8'(4*i+20)};
            step(1, w, 3'd4, 1, 4'd4, 0);
            checks++;
            if (o_window_count !== 4'(sb.size())) begin
                errors++;
                $display("FAIL wrap_cnt_%0d: got %0d need %0d", i, o_window_count, sb.size());
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (o_window[k] !== ((k < sb.size()) ? sb[k] : 8'h00)) begin
                    errors++;
                    $display("FAIL wrap_win_%0d[%0d]: got %h need %h", i, k, o_window[k],
                             (k < sb.size()) ? sb[k] : 8'h00);
                end
            end
        end
    endtask

    task automatic test_illegal_flush();
        step(0, 0, 0, 0, 0, 1);
        step(1, 32'h0000BBAA, 3'd2, 0, 0, 0);
        step(0, 0, 0, 1, 4'd5, 0);
        checks++;
        if (o_error !== 1'b1 || m_err !== 1'b1 || o_window_count !== 4'd2 ||
            o_window[0] !== 8'hAA || o_window[1] !== 8'hBB) begin
            errors++;
            $display("FAIL illegal_consume: err=%b cnt=%0d w0=%h w1=%h need 1 2 aa bb",
                     o_error, o_window_count, o_window[0], o_window[1]);
        end
        step(0, 0, 0, 1, 4'd0, 0);
        checks++;
        if (o_window_count !== 4'd2) begin
            errors++;
            $display("FAIL illegal_zero: cnt=%0d need 2", o_window_count);
        end
        step(1, 32'h11223344, 3'd4, 1, 4'd1, 1);
        checks++;
        if (o_empty !== 1'b1 || o_window_count !== 4'd0 || o_error !== 1'b1 || o_fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: empty=%b cnt=%0d err=%b ready=%b need 1 0 1 1",
                     o_empty, o_window_count, o_error, o_fetch_ready);
        end
    endtask

    task automatic test_async_reset();
        step(1, 32'h44434241, 3'd4, 0, 0, 0);
        step(1, 32'h48474645, 3'd4, 0, 0, 0);
        step(1, 32'h00004A49, 3'd2, 0, 0, 0);
        checks++;
        if (o_window_count !== 4'd8 || o_empty !== 1'b0 || o_window[0] !== 8'h41) begin
            errors++;
            $display("FAIL pre_reset: cnt=%0d empty=%b w0=%h need 8 0 41", o_window_count, o_empty, o_window[0]);
        end
        #3 i_reset_n = 1'b0;
        #1;
        sb.delete();
        m_err = 1'b0;
        checks++;
        if (o_empty !== 1'b1 || o_full !== 1'b0 || o_fetch_ready !== 1'b1 ||
            o_window_count !== 4'd0 || o_error !== 1'b0 || o_window[0] !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: empty=%b full=%b ready=%b cnt=%0d err=%b w0=%h need 1 0 1 0 0 00",
                     o_empty, o_full, o_fetch_ready, o_window_count, o_error, o_window[0]);
        end
        @(posedge i_clk); #3 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        step(1, 32'h000000C5, 3'd1, 0, 0, 0);
        checks++;
        if (o_window_count !== 4'd1 || o_window[0] !== 8'hC5 || o_window[1] !== 8'h00) begin
            errors++;
            $display("FAIL post_reset: cnt=%0d w0=%h w1=%h need 1 c5 00", o_window_count, o_window[0], o_window[1]);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_full();
        test_simultaneous();
        test_wrap();
        test_illegal_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_prefetch_queue.md
DECODE_PREFETCH_QUEUE -- requirements
Module: decode_prefetch_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 16, queue capacity in bytes (power of two, >= 8).
REQ-002 SHALL have port: i_clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: i_flush  input  1  discard all queued bytes (control transfer).
REQ-005 SHALL have port: i_fetch_valid  input  1  fetch word offered.
REQ-006 SHALL have port: i_fetch_data  input  32  fetch bytes, little-endian; byte 0 = [7:0].
REQ-007 SHALL have port: i_fetch_bytes  input  3  number of valid bytes in i_fetch_data, 1..4.
REQ-008 SHALL have port: o_fetch_ready  output  1  queue can accept a 4-byte fetch this cycle.
REQ-009 SHALL have port: o_window  output  8x8 (unpacked [0:7])  next 8 queued bytes, oldest at [0].
REQ-010 SHALL have port: o_window_count  output  4  valid bytes in o_window, 0..8.
REQ-011 SHALL have port: i_consume_valid  input  1  decoder retires bytes this cycle.
REQ-012 SHALL have port: i_consume_bytes  input  4  bytes retired, 1..8.
REQ-013 SHALL have port: o_empty  output  1  byte count == 0.
REQ-014 SHALL have port: o_full  output  1  byte count == DEPTH.
REQ-015 SHALL have port: o_error  output  1  sticky illegal-request flag.

Function
REQ-016 SHALL hold bytes in a DEPTH-entry byte array with write pointer, read pointer (log2 DEPTH bits, wrap modulo DEPTH) and count register (0..DEPTH).
REQ-017 SHALL drive o_fetch_ready = 1 iff DEPTH - count >= 4, from registered count only (no combinational path from consume inputs).
REQ-018 SHALL accept a fetch when i_fetch_valid & o_fetch_ready & !i_flush: write i_fetch_bytes bytes at write pointer upward, advance write pointer by i_fetch_bytes, wrapping.
REQ-019 SHALL ignore i_fetch_valid when o_fetch_ready = 0 (no write, no error).
REQ-020 SHALL drive o_window[k] = array[(rd_ptr + k) mod DEPTH] for k < o_window_count, and 8'h00 for k >= o_window_count; combinational from registered state.
REQ-021 SHALL drive o_window_count = min(count, 8).
REQ-022 SHALL accept a consume when i_consume_valid & !i_flush & 1 <= i_consume_bytes <= o_window_count: advance read pointer by i_consume_bytes, wrapping.
REQ-023 SHALL treat i_consume_valid with i_consume_bytes = 0 or > o_window_count as illegal: no pointer/count change, set o_error next edge.
REQ-024 SHALL, on simultaneous accepted fetch and consume, apply both in the same edge: count_next = count + i_fetch_bytes - i_consume_bytes.
REQ-025 SHALL give i_flush priority over fetch and consume: next edge rd_ptr = wr_ptr = 0, count = 0; same-cycle fetch data and consume discarded; o_error unchanged.
REQ-026 SHALL make bytes written at edge N visible in o_window from cycle N+1 (one-cycle latency); consumed bytes leave o_window from the next cycle.
REQ-027 SHALL drive o_empty = (count == 0), o_full = (count == DEPTH), both from registers.
REQ-028 SHALL keep o_error set until reset; flush does not clear it.
REQ-029 SHALL never let count exceed DEPTH or go below 0; guaranteed by REQ-017/REQ-022.

Reset
REQ-030 SHALL, while i_reset_n = 0, immediately force rd_ptr = 0, wr_ptr = 0, count = 0, o_error = 0; hence o_empty = 1, o_full = 0, o_fetch_ready = 1, o_window_count = 0, all o_window bytes 8'h00.
REQ-031 SHALL NOT require reset of the byte array contents (masked by REQ-020).
REQ-032 SHALL abandon any in-flight fetch/consume when reset asserts mid-cycle; first legal operation is on the first rising edge after deassertion.

Verification
REQ-033 SHALL pass: reset, fetch 0x44332211 bytes=4 -> next cycle o_window[0..3] = 11,22,33,44, o_window_count = 4, others 00, o_empty = 0.
REQ-034 SHALL pass: fetch 4 words to fill 16 bytes -> o_full = 1, o_fetch_ready = 0; further fetch ignored, count stays 16, o_error = 0.
REQ-035 SHALL pass: with 6 bytes queued, consume 3 and fetch 4 in the same cycle -> next o_window_count = 7, o_window[0] = former byte 3.
REQ-036 SHALL pass: wrap-around -- repeatedly fetch 4 / consume 4 for 10 cycles -> o_window contents track input sequence exactly across pointer wrap at 16.
REQ-037 SHALL pass: with 2 bytes queued, consume 5 -> state unchanged, o_error = 1 next cycle and stays 1 after i_flush; i_flush with fetch_valid -> count = 0, o_empty = 1.
REQ-038 SHALL pass: assert i_reset_n = 0 asynchronously mid-cycle with 10 bytes queued -> outputs reach reset values before next clock edge.
